// File: rtl/des3_ctrl_pkg.sv
// Shared types and widths for the 3DES round controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package des3_ctrl_pkg;

    localparam int NUM_ROUNDS_DEF = 48;
    localparam int BLK_W          = 64;
    localparam int KEY_W          = 56;
    localparam int RSEL_W         = 6;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/des3_round_cnt.sv
// Round counter: counts 0..MAX_COUNT-1 while enabled, flags the last round.
// Latency: count updates one edge after enable; tc is combinational on count.
// Backpressure: none; clear has priority over enable, wraps to 0 after the last round.
module des3_round_cnt #(
    parameter int MAX_COUNT = 48,
    parameter int W         = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

    assign tc = (count == LAST);

    // Counter register: clear wins, the last round wraps back to 0 so the
    // out-of-range values are never reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/des3_round_ctrl.sv
// Sequences a round-iterated 3DES core: accept block, step NUM_ROUNDS rounds, capture, present.
// Latency: out_valid rises NUM_ROUNDS+1 edges after the accepting edge.
// Backpressure: single op in flight; in_ready only in IDLE, result held until out_ready.
// Optional: DES3_CTRL_KEY_LATCH_EN registers keys/decrypt on accept instead of passing them through.
module des3_round_ctrl
    import des3_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    input  logic              in_decrypt,
    input  logic [KEY_W-1:0]  key1_i,
    input  logic [KEY_W-1:0]  key2_i,
    input  logic [KEY_W-1:0]  key3_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic              busy,
    output logic [BLK_W-1:0]  core_desIn,
    output logic [KEY_W-1:0]  core_key1,
    output logic [KEY_W-1:0]  core_key2,
    output logic [KEY_W-1:0]  core_key3,
    output logic              core_decrypt,
    output logic [RSEL_W-1:0] core_roundSel,
    input  logic [BLK_W-1:0]  core_desOut
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                cnt_en;
    logic                cnt_tc;
    logic [RSEL_W-1:0]   cnt;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);
    assign cnt_en    = (state == ST_RUN);

    // Round select is only meaningful while iterating; park it at 0 otherwise
    assign core_roundSel = (state == ST_RUN) ? cnt : '0;

    des3_round_cnt #(
        .MAX_COUNT (NUM_ROUNDS),
        .W         (RSEL_W)
    ) u_round_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (cnt_en),
        .count  (cnt),
        .tc     (cnt_tc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_RUN;
            ST_RUN:  if (cnt_tc)    state_nxt = ST_CAPT;
            ST_CAPT:                state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Input block register: loaded only on accept so the core sees a stable block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_desIn <= '0;
        end else if (accept) begin
            core_desIn <= in_data;
        end
    end

    // Result register: sampled from the core in CAPT, then held through OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (state == ST_CAPT) begin
            out_data <= core_desOut;
        end
    end

`ifdef DES3_CTRL_KEY_LATCH_EN
    // Key/direction latch: host may change keys once the request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_key1    <= '0;
            core_key2    <= '0;
            core_key3    <= '0;
            core_decrypt <= 1'b0;
        end else if (accept) begin
            core_key1    <= key1_i;
            core_key2    <= key2_i;
            core_key3    <= key3_i;
            core_decrypt <= in_decrypt;
        end
    end
`else
    // Pass-through: host holds keys and direction stable for the whole operation
    assign core_key1    = key1_i;
    assign core_key2    = key2_i;
    assign core_key3    = key3_i;
    assign core_decrypt = in_decrypt;
`endif

endmodule

// File: tb/tb_des3_round_ctrl.sv
// Bench for des3_round_ctrl with a behavioural core stand-in that only yields a
// valid result after seeing round selects 0..47 in order; known 3DES pairs are tabled.
module tb_des3_round_ctrl;

    localparam int NR = 48;
    localparam logic [55:0] KREF = 56'h12695BC9B7B7F8;
    localparam logic [63:0] PREF = 64'h0123456789ABCDEF;
    localparam logic [63:0] CREF = 64'h85E813540F0AB405;
    localparam logic [63:0] BAD  = 64'hBAD0BAD0BAD0BAD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_decrypt;
    logic [55:0] key1_i, key2_i, key3_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [63:0] core_desIn;
    logic [55:0] core_key1, core_key2, core_key3;
    logic        core_decrypt;
    logic [5:0]  core_roundSel;
    logic [63:0] core_desOut;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    des3_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_decrypt    (in_decrypt),
        .key1_i        (key1_i),
        .key2_i        (key2_i),
        .key3_i        (key3_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .core_desIn    (core_desIn),
        .core_key1     (core_key1),
        .core_key2     (core_key2),
        .core_key3     (core_key3),
        .core_decrypt  (core_decrypt),
        .core_roundSel (core_roundSel),
        .core_desOut   (core_desOut)
    );

    // Core stand-in: reference 3DES pairs for the known key, a simple mix otherwise
    function automatic logic [63:0] model_core(input logic [63:0] d, input logic dec,
                                               input logic [55:0] k1, input logic [55:0] k2,
                                               input logic [55:0] k3);
        logic [63:0] m;
        if (k1 == KREF && k2 == KREF && k3 == KREF && !dec && d == PREF) return CREF;
        if (k1 == KREF && k2 == KREF && k3 == KREF &&  dec && d == CREF) return PREF;
        m = d ^ {k1, 8'h00} ^ {8'h00, k2} ^ {k3[27:0], k3[55:20]};
        return dec ? ~m : m;
    endfunction

    // Tracks that the round selects walked 0,1,..,NR-1 on consecutive edges
    logic [6:0] seen;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen <= 7'd0;
        else if (core_roundSel == 6'd0) seen <= 7'd1;
        else if ({1'b0, core_roundSel} == seen) seen <= seen + 7'd1;
        else seen <= 7'd0;
    end
    assign core_desOut = (seen == 7'(NR)) ?
        model_core(core_desIn, core_decrypt, core_key1, core_key2, core_key3) : BAD;

    typedef struct {
        logic [63:0] din;
        logic        dec;
        logic [55:0] k1, k2, k3;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic set_keys(input logic [55:0] a, input logic [55:0] b, input logic [55:0] c);
        key1_i = a; key2_i = b; key3_i = c;
    endtask

    // Present a request, wait for accept, then count edges until out_valid
    task automatic start_and_wait(input logic [63:0] d, input logic dec, output int lat);
        int n;
        in_data = d; in_decrypt = dec; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        step();                         // accepting edge
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin step(); lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        logic [63:0] held;
        int acc_cyc[4];
        int n_acc;
        int width;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0;
        out_ready = 1'b0; set_keys(KREF, KREF, KREF);

        vecs[0] = '{PREF, 1'b0, KREF, KREF, KREF, CREF};
        vecs[1] = '{CREF, 1'b1, KREF, KREF, KREF, PREF};
        vecs[2] = '{64'hFFFF0000AAAA5555, 1'b0, 56'h1, 56'h2, 56'h3, 64'h0};
        vecs[3] = '{64'h0, 1'b1, '1, 56'h00F0F0F0F0F0F0, 56'hA5A5A5A5A5A5A5, 64'h0};
        vecs[2].exp_out = model_core(vecs[2].din, vecs[2].dec, vecs[2].k1, vecs[2].k2, vecs[2].k3);
        vecs[3].exp_out = model_core(vecs[3].din, vecs[3].dec, vecs[3].k1, vecs[3].k2, vecs[3].k3);

        // Reset state
        step(); step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_roundsel", 64'(core_roundSel), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_desin", core_desIn, 64'd0);
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 4; i++) begin
            set_keys(vecs[i].k1, vecs[i].k2, vecs[i].k3);
            start_and_wait(vecs[i].din, vecs[i].dec, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NR + 1));
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_out);
            chk($sformatf("vec%0d_desin", i), core_desIn, vecs[i].din);
            chk($sformatf("vec%0d_key1", i), 64'(core_key1), 64'(vecs[i].k1));
            chk($sformatf("vec%0d_dec", i), 64'(core_decrypt), 64'(vecs[i].dec));
            release_out();
            chk($sformatf("vec%0d_idle_ready", i), 64'(in_ready), 64'd1);
            chk($sformatf("vec%0d_idle_valid", i), 64'(out_valid), 64'd0);
        end

        // Result held for 20 cycles with out_ready low; in_valid pulses ignored
        set_keys(KREF, KREF, KREF);
        start_and_wait(PREF, 1'b0, lat);
        chk("hold_latency", 64'(lat), 64'(NR + 1));
        held = out_data;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_data  = 64'($urandom) << 32 | 64'($urandom);
            step();
            chk("hold_data", out_data, CREF);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_roundsel", 64'(core_roundSel), 64'd0);
            chk("hold_desin", core_desIn, PREF);
        end
        in_valid = 1'b0;
        chk("hold_first_data", held, CREF);
        release_out();

        // Asynchronous reset in the middle of a run
        in_data = PREF; in_decrypt = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (core_roundSel != 6'd23 && n < 200) begin step(); n++; end
        chk("midrst_reached_23", 64'(core_roundSel), 64'd23);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_roundsel", 64'(core_roundSel), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_desin", core_desIn, 64'd0);
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            chk("midrst_no_output", 64'(out_valid), 64'd0);
        end
        start_and_wait(CREF, 1'b1, lat);
        chk("postrst_latency", 64'(lat), 64'(NR + 1));
        chk("postrst_data", out_data, PREF);
        release_out();

`ifdef DES3_CTRL_KEY_LATCH_EN
        // Key change mid-run must not affect the latched operation
        in_data = PREF; in_decrypt = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (core_roundSel != 6'd10 && n < 200) begin step(); n++; end
        key1_i = 56'hFFFFFFFFFFFFFF;
        in_decrypt = 1'b1;
        n = 0;
        while (!out_valid && n < 200) begin step(); n++; end
        chk("keylatch_valid", 64'(out_valid), 64'd1);
        chk("keylatch_data", out_data, CREF);
        release_out();
        set_keys(KREF, KREF, KREF);
        in_decrypt = 1'b0;
`endif

        // Back-to-back with out_ready tied high
        out_ready = 1'b1; in_data = PREF; in_decrypt = 1'b0; in_valid = 1'b1;
        n_acc = 0; width = 0;
        for (int c = 0; c < 400 && n_acc < 4; c++) begin
            if (in_ready) begin acc_cyc[n_acc] = cyc; n_acc++; end
            step();
            if (out_valid) begin
                width++;
                chk("b2b_data", out_data, CREF);
            end else if (width != 0) begin
                chk("b2b_pulse_width", 64'(width), 64'd1);
                width = 0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'd4);
        for (int i = 0; i < 3; i++)
            chk("b2b_spacing", 64'(acc_cyc[i+1] - acc_cyc[i]), 64'(NR + 3));
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        chk("b2b_drain_idle", 64'(busy), 64'd0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des3_round_ctrl.md
DES3_ROUND_CTRL -- requirements
Module: des3_round_ctrl

Interface
REQ-001 The block SHALL have one parameter: NUM_ROUNDS, default 48, the number of core round cycles per 3DES operation.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: host request valid.
REQ-006 Port in_ready, output, 1 bit: the controller can accept a request.
REQ-007 Port in_data, input, 64 bits: plaintext or ciphertext block.
REQ-008 Port in_decrypt, input, 1 bit: 1 selects decrypt, 0 selects encrypt.
REQ-009 Ports key1_i, key2_i and key3_i, each input, 56 bits: the 3DES keys, parity bits stripped.
REQ-010 Port out_valid, output, 1 bit: a result is held on out_data.
REQ-011 Port out_ready, input, 1 bit: the host accepts the result.
REQ-012 Port out_data, output, 64 bits: the result block.
REQ-013 Port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 Ports core_desIn (64 bits), core_key1, core_key2 and core_key3 (56 bits each), core_decrypt (1 bit) and core_roundSel (6 bits), all outputs, SHALL drive the round-iterated 3DES core.
REQ-015 Port core_desOut, input, 64 bits: the core result.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, CAPT and OUT.
REQ-017 in_ready SHALL be 1 only in IDLE; an operation is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 On accept, the block SHALL register in_data into core_desIn, clear the round counter to 0 and move to RUN.
REQ-019 In RUN, core_roundSel SHALL equal the round counter, which increments by 1 per cycle from 0 to NUM_ROUNDS-1. The edge at NUM_ROUNDS-1 SHALL move the FSM to CAPT; the counter never reaches values 48..63.
REQ-020 In IDLE, CAPT and OUT, core_roundSel SHALL be 0.
REQ-021 In CAPT, the block SHALL register core_desOut into out_data at the clock edge and move to OUT.
REQ-022 out_valid SHALL be 1 only in OUT, rising exactly NUM_ROUNDS+1 edges after the accepting edge (49 by default).
REQ-023 In OUT, out_data SHALL be held stable; the edge with out_ready=1 SHALL return the FSM to IDLE. The next accept is possible one cycle later, with no overlap.
REQ-024 If out_ready is already 1 when OUT is entered, the FSM SHALL return to IDLE on the next edge, so out_valid is high for one cycle.
REQ-025 in_valid, in_data, in_decrypt and the keys SHALL be ignored outside IDLE.
REQ-026 core_desIn SHALL change only on an accept edge.

Reset
REQ-027 Asserting rst_n low, at any time including mid-RUN, SHALL immediately force: FSM to IDLE, round counter 0, out_data 0, core_desIn 0, out_valid 0, busy 0, core_roundSel 0, in_ready 1.
REQ-028 Any operation in flight at reset SHALL be discarded; no output is produced for it.
REQ-029 Release of rst_n SHALL be sampled synchronously; the first accept is possible on the first edge after release.

Configuration
REQ-030 With DES3_CTRL_KEY_LATCH_EN defined, key1_i..key3_i and in_decrypt SHALL be registered on the accept edge (reset value 0) and held on core_key1..3 and core_decrypt until the next accept.
REQ-031 Without DES3_CTRL_KEY_LATCH_EN, core_key1..3 and core_decrypt SHALL be combinational pass-throughs of the inputs, and the host must hold them stable from accept until out_valid.

Structure
REQ-032 Package des3_ctrl_pkg SHALL hold the FSM state enum, NUM_ROUNDS_DEF=48, the block width 64, the key width 56 and the roundSel width 6.
REQ-033 The round counter SHALL be a sub-module, des3_round_cnt, with inputs clear and enable and outputs count and terminal-count.

Verification
REQ-034 Keys all 0x12695BC9B7B7F8, in_data=0x0123456789ABCDEF, in_decrypt=0 -> out_valid 49 edges after accept; out_data=0x85E813540F0AB405.
REQ-035 Same keys, in_data=0x85E813540F0AB405, in_decrypt=1 -> out_data=0x0123456789ABCDEF.
REQ-036 Hold out_ready=0 for 20 cycles after out_valid -> out_data stable; in_ready=0; in_valid pulses are ignored; core_roundSel=0.
REQ-037 Assert rst_n low at round 23 -> out_valid=0, busy=0 and core_roundSel=0 immediately. A new request afterwards completes in 49 edges with the correct result.
REQ-038 With DES3_CTRL_KEY_LATCH_EN, change key1_i at round 10 -> result unchanged from REQ-034. Without the macro, a mismatch is expected and the test is skipped.
REQ-039 Back-to-back requests with out_ready tied to 1 -> each out_valid lasts one cycle; accepts are spaced NUM_ROUNDS+3 = 51 edges apart.
